// File: rtl/rx_sched_pkg.sv
// Shared definitions for the RX FIFO write-side scheduler: tag word,
// FSM state encoding and the channel-count clamp.
package rx_sched_pkg;

    localparam int          MAX_CHANNELS = 8;
    localparam logic [15:0] DATA_TAG     = 16'h4000;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Map the raw channel field onto the legal range 1..MAX_CHANNELS.
    function automatic logic [3:0] clamp_channels(input logic [3:0] ch);
        if (ch == 4'd0) begin
            return 4'd1;
        end else if (ch > 4'(MAX_CHANNELS)) begin
            return 4'(MAX_CHANNELS);
        end else begin
            return ch;
        end
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter with synchronous clear. A clear and an
// increment in the same cycle leave the count at 1 so the event is not lost.
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] count
);

    // Clear has priority but still counts a coincident event; hold at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= inc ? 16'd1 : 16'd0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/rx_write_sched.sv
// Write-side scheduler for the dual-clock RX FIFO (wr_clk domain).
// Captures up to 8 channel samples per decimator strobe and emits them one
// 16-bit word per clock on the FIFO write port. The first set of each gate
// window is replaced by DATA_TAG words. Sets that do not fit, or that arrive
// while a set is still being shifted out, are dropped whole and counted.
// Handshake: wr_req is a plain write enable with no back-pressure; the FIFO
// must accept every word presented while wr_req=1. Space is reserved up front
// by the fifo_level check so this always holds.
// Optional build macro RX_SCHED_DEBUG_EN drives the debug bus; otherwise it
// is tied to zero.
module rx_write_sched #(
    parameter int          FIFO_DEPTH = 4096,
    parameter int          HEADROOM   = 16,
    parameter logic [15:0] DATA_TAG   = rx_sched_pkg::DATA_TAG
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         strobe,
    input  logic         gate_enable,
    input  logic [3:0]   channels,
    input  logic [127:0] din,
    input  logic [11:0]  fifo_level,
    input  logic         clear_status,
    output logic         wr_req,
    output logic [15:0]  wr_data,
    output logic         busy,
    output logic         overflow,
    output logic         collision,
    output logic [15:0]  drop_count,
    output logic [15:0]  win_count,
    output logic [15:0]  debug
);

    import rx_sched_pkg::*;

    localparam logic [12:0] SPACE_LIMIT = 13'(FIFO_DEPTH - HEADROOM);

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [3:0]  n_q;
    logic [15:0] slot_q [MAX_CHANNELS];
    logic        first_q;
    logic        gate_q;
    logic        wr_req_q;
    logic [15:0] wr_data_q;
    logic        overflow_q;
    logic        collision_q;

    logic [3:0]  n_now;
    logic        gate_rise;
    logic        tag_set;
    logic        last_word;
    logic        can_start;
    logic        space_ok;
    logic        accept;
    logic        space_drop;
    logic        coll_drop;
    logic [2:0]  idx_nxt;

    assign n_now      = clamp_channels(channels);
    assign gate_rise  = gate_enable & ~gate_q;
    // A rising gate edge in the acceptance cycle already makes this a tag set.
    assign tag_set    = first_q | gate_rise;
    assign last_word  = (state_q == SHIFT) && (idx_q == 3'(n_q - 4'd1));
    assign can_start  = (state_q == IDLE) || last_word;
    assign space_ok   = ({1'b0, fifo_level} + {9'd0, n_now}) <= SPACE_LIMIT;
    assign accept     = strobe & gate_enable & can_start & space_ok;
    assign space_drop = strobe & gate_enable & can_start & ~space_ok;
    assign coll_drop  = strobe & gate_enable & ~can_start;
    assign idx_nxt    = idx_q + 3'd1;

    // Scheduler FSM: wr_req/wr_data are registered and present slot[idx].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            n_q       <= 4'd1;
            wr_req_q  <= 1'b0;
            wr_data_q <= 16'd0;
        end else if (accept) begin
            state_q   <= SHIFT;
            idx_q     <= 3'd0;
            n_q       <= n_now;
            wr_req_q  <= 1'b1;
            wr_data_q <= tag_set ? DATA_TAG : din[15:0];
        end else if (state_q == SHIFT) begin
            if (last_word) begin
                state_q  <= IDLE;
                idx_q    <= 3'd0;
                wr_req_q <= 1'b0;
            end else begin
                idx_q     <= idx_nxt;
                wr_req_q  <= 1'b1;
                wr_data_q <= slot_q[idx_nxt];
            end
        end
    end

    // Sample latch: all eight slots captured at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAX_CHANNELS; k++) begin
                slot_q[k] <= 16'd0;
            end
        end else if (accept) begin
            for (int k = 0; k < MAX_CHANNELS; k++) begin
                slot_q[k] <= tag_set ? DATA_TAG : din[16*k +: 16];
            end
        end
    end

    // Window tracking and sticky drop flags; a drop beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_q      <= 1'b0;
            first_q     <= 1'b1;
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            gate_q <= gate_enable;
            if (accept) begin
                first_q <= 1'b0;
            end else if (gate_rise) begin
                first_q <= 1'b1;
            end
            if (space_drop) begin
                overflow_q <= 1'b1;
            end else if (clear_status) begin
                overflow_q <= 1'b0;
            end
            if (coll_drop) begin
                collision_q <= 1'b1;
            end else if (clear_status) begin
                collision_q <= 1'b0;
            end
        end
    end

    sat_counter16 u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear_status),
        .inc   (space_drop | coll_drop),
        .count (drop_count)
    );

    sat_counter16 u_win_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (gate_rise),
        .inc   (accept),
        .count (win_count)
    );

    assign wr_req    = wr_req_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q == SHIFT);
    assign overflow  = overflow_q;
    assign collision = collision_q;

`ifdef RX_SCHED_DEBUG_EN
    assign debug = {win_count[7:0], idx_q, first_q, collision_q, overflow_q, busy, wr_req_q};
`else
    assign debug = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_write_sched.sv
// Bench for rx_write_sched: a table of hand-computed cycle vectors, two
// hand-written multi-cycle sequences and randomized traffic, all checked
// against a queue-based model of the emitted word stream.
module tb_rx_write_sched;

    logic         clk;
    logic         reset;
    logic         strobe;
    logic         gate_enable;
    logic [3:0]   channels;
    logic [127:0] din;
    logic [11:0]  fifo_level;
    logic         clear_status;
    logic         wr_req;
    logic [15:0]  wr_data;
    logic         busy;
    logic         overflow;
    logic         collision;
    logic [15:0]  drop_count;
    logic [15:0]  win_count;
    logic [15:0]  debug;

    int checks = 0;
    int errors = 0;

    // Model state: words still to be written, exp_q[0] is the one on the bus.
    logic [15:0] exp_q[$];
    bit          m_first;
    bit          m_gate_prev;
    bit          m_ovf;
    bit          m_coll;
    int          m_drop;
    int          m_win;

    typedef struct {
        logic        gate;
        logic [3:0]  ch;
        logic        stb;
        logic [11:0] fl;
        logic        clr;
        logic        e_req;
        logic [15:0] e_data;
        logic        e_ovf;
        logic        e_coll;
        logic [15:0] e_drop;
        logic [15:0] e_win;
    } vec_t;

    vec_t vecs[$];

    rx_write_sched dut (
        .clk          (clk),
        .reset        (reset),
        .strobe       (strobe),
        .gate_enable  (gate_enable),
        .channels     (channels),
        .din          (din),
        .fifo_level   (fifo_level),
        .clear_status (clear_status),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .busy         (busy),
        .overflow     (overflow),
        .collision    (collision),
        .drop_count   (drop_count),
        .win_count    (win_count),
        .debug        (debug)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_first     = 1'b1;
        m_gate_prev = 1'b0;
        m_ovf       = 1'b0;
        m_coll      = 1'b0;
        m_drop      = 0;
        m_win       = 0;
    endtask

    // One clock edge of the behavioural model, using the inputs held at the edge.
    task automatic model_edge();
        int  n;
        bit  rise;
        bit  free_slot;
        bit  fits;
        rise        = gate_enable && !m_gate_prev;
        m_gate_prev = gate_enable;
        n           = (channels == 0) ? 1 : ((channels > 8) ? 8 : int'(channels));
        free_slot   = exp_q.size() <= 1;
        fits        = (int'(fifo_level) + n) <= 4096 - 16;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (clear_status) begin
            m_drop = 0;
            m_ovf  = 1'b0;
            m_coll = 1'b0;
        end
        if (rise) begin
            m_first = 1'b1;
            m_win   = 0;
        end
        if (strobe && gate_enable) begin
            if (!free_slot) begin
                m_coll = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else if (!fits) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else begin
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back(m_first ? 16'h4000 : din[16*k +: 16]);
                end
                m_first = 1'b0;
                if (m_win < 65535) m_win++;
            end
        end
    endtask

    task automatic check_model();
        bit exp_req;
        exp_req = exp_q.size() > 0;
        chk("model_wr_req", {31'd0, wr_req}, {31'd0, exp_req});
        chk("model_busy", {31'd0, busy}, {31'd0, exp_req});
        if (exp_req) chk("model_wr_data", {16'd0, wr_data}, {16'd0, exp_q[0]});
        chk("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("model_collision", {31'd0, collision}, {31'd0, m_coll});
        chk("model_drop_count", {16'd0, drop_count}, 32'(m_drop));
        chk("model_win_count", {16'd0, win_count}, 32'(m_win));
`ifdef RX_SCHED_DEBUG_EN
        chk("model_debug_low", {30'd0, debug[1:0]}, {30'd0, exp_req, exp_req});
`else
        chk("model_debug", {16'd0, debug}, 32'd0);
`endif
    endtask

    // Driver: inputs were set at the falling edge; advance one cycle and check.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input bit g, input int ch, input bit s, input int fl, input bit c);
        gate_enable  = g;
        channels     = 4'(ch);
        strobe       = s;
        fifo_level   = 12'(fl);
        clear_status = c;
    endtask

    function automatic vec_t mk(input int g, input int ch, input int s, input int fl,
                                input int c, input int r, input int d, input int o,
                                input int co, input int dr, input int w);
        vec_t v;
        v.gate   = 1'(g);
        v.ch     = 4'(ch);
        v.stb    = 1'(s);
        v.fl     = 12'(fl);
        v.clr    = 1'(c);
        v.e_req  = 1'(r);
        v.e_data = 16'(d);
        v.e_ovf  = 1'(o);
        v.e_coll = 1'(co);
        v.e_drop = 16'(dr);
        v.e_win  = 16'(w);
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_req"}, {31'd0, wr_req}, 32'd0);
        chk({tag, "_wr_data"}, {16'd0, wr_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_collision"}, {31'd0, collision}, 32'd0);
        chk({tag, "_drop_count"}, {16'd0, drop_count}, 32'd0);
        chk({tag, "_win_count"}, {16'd0, win_count}, 32'd0);
        chk({tag, "_debug"}, {16'd0, debug}, 32'd0);
    endtask

    initial begin
        logic [127:0] din_fix;
        int           run_len;
        bit           seen_low;

        for (int k = 0; k < 8; k++) din_fix[16*k +: 16] = 16'(k + 1);

        // Reset block
        reset = 1'b1;
        drive(0, 4, 0, 0, 0);
        din = din_fix;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        model_reset();

        // Vector table: gate ch stb fifo_level clr | req data ovf coll drop win
        vecs.push_back(mk(1, 4, 0, 0, 0,    0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(1, 4, 1, 0, 0,    1, 'h4000,  0, 0, 0, 1));
        vecs.push_back(mk(1, 4, 0, 0, 0,    1, 'h4000,  0, 0, 0, 1));
        vecs.push_back(mk(1, 4, 0, 0, 0,    1, 'h4000,  0, 0, 0, 1));
        vecs.push_back(mk(1, 4, 0, 0, 0,    1, 'h4000,  0, 0, 0, 1));
        vecs.push_back(mk(1, 4, 0, 0, 0,    0, 0,       0, 0, 0, 1));
        vecs.push_back(mk(1, 4, 1, 0, 0,    1, 1,       0, 0, 0, 2));
        vecs.push_back(mk(1, 4, 0, 0, 0,    1, 2,       0, 0, 0, 2));
        vecs.push_back(mk(1, 4, 0, 0, 0,    1, 3,       0, 0, 0, 2));
        vecs.push_back(mk(1, 4, 0, 0, 0,    1, 4,       0, 0, 0, 2));
        vecs.push_back(mk(1, 4, 0, 0, 0,    0, 0,       0, 0, 0, 2));
        vecs.push_back(mk(1, 2, 1, 0, 0,    1, 1,       0, 0, 0, 3));
        vecs.push_back(mk(1, 2, 1, 0, 0,    1, 2,       0, 1, 1, 3));
        vecs.push_back(mk(1, 2, 0, 0, 0,    0, 0,       0, 1, 1, 3));
        vecs.push_back(mk(1, 2, 0, 0, 1,    0, 0,       0, 0, 0, 3));
        vecs.push_back(mk(1, 4, 1, 4076, 0, 1, 1,       0, 0, 0, 4));
        vecs.push_back(mk(1, 4, 0, 4076, 0, 1, 2,       0, 0, 0, 4));
        vecs.push_back(mk(1, 4, 0, 4076, 0, 1, 3,       0, 0, 0, 4));
        vecs.push_back(mk(1, 4, 0, 4076, 0, 1, 4,       0, 0, 0, 4));
        vecs.push_back(mk(1, 4, 0, 4077, 0, 0, 0,       0, 0, 0, 4));
        vecs.push_back(mk(1, 4, 1, 4077, 0, 0, 0,       1, 0, 1, 4));
        vecs.push_back(mk(1, 4, 1, 4077, 1, 0, 0,       1, 0, 1, 4));
        vecs.push_back(mk(1, 4, 0, 4077, 1, 0, 0,       0, 0, 0, 4));
        vecs.push_back(mk(1, 0, 1, 0, 0,    1, 1,       0, 0, 0, 5));
        vecs.push_back(mk(1, 0, 1, 0, 0,    1, 1,       0, 0, 0, 6));
        vecs.push_back(mk(1, 0, 0, 0, 0,    0, 0,       0, 0, 0, 6));
        vecs.push_back(mk(1, 12, 1, 0, 0,   1, 1,       0, 0, 0, 7));
        for (int k = 2; k <= 8; k++) vecs.push_back(mk(1, 12, 0, 0, 0, 1, k, 0, 0, 0, 7));
        vecs.push_back(mk(1, 12, 0, 0, 0,   0, 0,       0, 0, 0, 7));
        vecs.push_back(mk(0, 12, 1, 0, 0,   0, 0,       0, 0, 0, 7));
        vecs.push_back(mk(1, 12, 1, 0, 0,   1, 'h4000,  0, 0, 0, 1));
        for (int k = 0; k < 7; k++) vecs.push_back(mk(1, 12, 0, 0, 0, 1, 'h4000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 12, 0, 0, 0,   0, 0,       0, 0, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].gate, int'(vecs[i].ch), vecs[i].stb, int'(vecs[i].fl), vecs[i].clr);
            step();
            chk($sformatf("vec%0d_wr_req", i), {31'd0, wr_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req) chk($sformatf("vec%0d_wr_data", i), {16'd0, wr_data}, {16'd0, vecs[i].e_data});
            chk($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].e_ovf});
            chk($sformatf("vec%0d_collision", i), {31'd0, collision}, {31'd0, vecs[i].e_coll});
            chk($sformatf("vec%0d_drop_count", i), {16'd0, drop_count}, {16'd0, vecs[i].e_drop});
            chk($sformatf("vec%0d_win_count", i), {16'd0, win_count}, {16'd0, vecs[i].e_win});
        end

        // Back-to-back 8-channel sets: second strobe on the last-word cycle.
        run_len  = 0;
        seen_low = 1'b0;
        for (int s = 0; s <= 16; s++) begin
            drive(1, 8, (s == 0) || (s == 8), 0, 0);
            step();
            if (wr_req && !seen_low) run_len++;
            else seen_low = 1'b1;
        end
        chk("b2b_contiguous_words", 32'(run_len), 32'd16);
        chk("b2b_collision", {31'd0, collision}, 32'd0);

        // Asynchronous reset in the middle of a set.
        drive(1, 4, 1, 0, 0);
        step();
        drive(1, 4, 0, 0, 0);
        step();
        chk("midset_wr_req_before", {31'd0, wr_req}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midset_reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        drive(1, 4, 1, 0, 0);
        step();
        chk("after_reset_tag_word", {16'd0, wr_data}, 32'h4000);
        drive(1, 4, 0, 0, 0);
        repeat (5) step();

        // Randomized traffic checked against the model.
        for (int i = 0; i < 800; i++) begin
            logic g;
            g = ($urandom_range(0, 99) < 3) ? ~gate_enable : gate_enable;
            for (int k = 0; k < 4; k++) din[32*k +: 32] = $urandom;
            drive(g, $urandom_range(0, 15), $urandom_range(0, 9) < 3,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(4060, 4095) : $urandom_range(0, 4000),
                  $urandom_range(0, 99) < 5);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_write_sched.md
Name: rx_write_sched

Overview:
Write-side scheduler for the dual-clock RX FIFO. It captures up to 8 channel samples on each decimator strobe and serializes them into the FIFO write port, one 16-bit word per clock. It substitutes the data tag for the first sample set of every gate window and refuses sample sets the FIFO cannot hold. It also keeps drop and collision accounting for the host status path. It sits between the DDC outputs and the FIFO write side, in the wr_clk domain.

Parameters:
FIFO_DEPTH, 4096, FIFO capacity in words; the fifo_level width must cover it.
HEADROOM, 16, words kept free as margin for FIFO level latency.
DATA_TAG, 16'h4000, word emitted in place of every channel of the first set in a window.

Ports:
clk  in  1  write-domain clock (wr_clk).
reset  in  1  asynchronous, active-high reset.
strobe  in  1  sample-valid pulse from the decimators; one cycle wide.
gate_enable  in  1  receive window active.
channels  in  4  active channel count; 0 is treated as 1, values above 8 as 8.
din  in  128  din[16k+15:16k] is channel k, for k = 0..7.
fifo_level  in  12  FIFO write-side used words.
clear_status  in  1  clears sticky flags and counters.
wr_req  out  1  FIFO write enable.
wr_data  out  16  FIFO write data.
busy  out  1  serialization in progress.
overflow  out  1  sticky: at least one set dropped for lack of space.
collision  out  1  sticky: a strobe arrived while busy and was not accepted.
drop_count  out  16  saturating count of dropped sets, from both causes.
win_count  out  16  sets accepted in the current window.
debug  out  16  debug bus.

Behaviour:
- Reset: all outputs 0, state IDLE, first-set flag 1.
- States: IDLE and SHIFT. Word index idx is 3 bits; the latch holds 8x16.
- Effective channel count n: 1..8 after clamping. n is latched at acceptance; a change to channels mid-set has no effect until the next set.
- Accept condition at strobe:
  - gate_enable=1;
  - state is IDLE, or SHIFT with idx=n-1 (the last word);
  - fifo_level + n <= FIFO_DEPTH - HEADROOM.
  - The comparison uses 13-bit unsigned arithmetic.
- Strobe with gate_enable=0: ignored, no counting.
- On acceptance in cycle t:
  - latch din, or DATA_TAG in all 8 slots if the first-set flag is 1;
  - clear the first-set flag;
  - win_count += 1, saturating at 16'hFFFF;
  - go to SHIFT with idx=0.
- SHIFT:
  - wr_req=1 and wr_data=slot[idx] in every SHIFT cycle;
  - the first word is in cycle t+1 and the last in cycle t+n, giving exactly n words;
  - idx increments each cycle;
  - at idx=n-1 return to IDLE, unless a new set is accepted in that same cycle, which restarts at idx=0 with no gap.
- Space failure: the whole set is dropped, with no partial writes. overflow is set and drop_count incremented.
- Strobe while busy and not on the last word: the set is dropped. collision is set and drop_count incremented.
- Window boundaries:
  - Falling gate_enable does not abort a set in flight; it completes.
  - Rising edge of gate_enable (registered compare) sets the first-set flag to 1 and clears win_count to 0.
  - If the rising edge and a strobe occur in the same cycle, the set is accepted as a tag set.
- busy=1 exactly in SHIFT.
- clear_status clears overflow, collision and drop_count next cycle. If a drop happens in the same cycle, the drop wins: flag=1, count=1.
- Asynchronous reset mid-SHIFT: wr_req drops immediately. Partial sets are not resumed.

Optional Feature:
RX_SCHED_DEBUG_EN. When defined, debug = {win_count[7:0], idx, first-set flag, collision, overflow, busy, wr_req}. When not defined, debug is tied to 16'h0000 and no extra registers are built.

Decomposition:
- Package rx_sched_pkg holds:
  - DATA_TAG;
  - the state enum {IDLE, SHIFT};
  - MAX_CHANNELS=8;
  - the function that clamps channels to 1..8.
- One natural sub-module: sat_counter16, which provides increment, clear, and saturation. It is instantiated for drop_count and win_count.

Test Plan:
- Reset, then rise gate_enable, channels=4, strobe with din ch0..3=1,2,3,4 -> wr_req high cycles t+1..t+4, wr_data=4000,4000,4000,4000. Next strobe -> 1,2,3,4; win_count=2.
- channels=8, strobe on the last-word cycle of the previous set -> 16 contiguous wr_req cycles with no gap. collision=0.
- channels=2, strobe 1 cycle after acceptance -> no extra words, collision=1, drop_count=1. clear_status -> both 0.
- fifo_level=4076, channels=4 -> accepted (4080 <= 4080). fifo_level=4077 -> no wr_req, overflow=1, drop_count=1.
- channels=0 -> one word per set. channels=12 -> eight words per set.
- Assert reset mid-SHIFT -> wr_req=0 within the same cycle. After release, the first set of the new window is tag words.
